state_step_engine: RTL

STATE_STEP_ENGINE -- requirements
Module: state_step_engine

---
 rtl/state_step_engine.sv | 134 +++++++++++++
 1 files changed

// File: rtl/state_step_engine.sv
// state_step_engine
//   Steps a game state vector through an external combinational rule. Each
//   accepted command loads the rule's next state and pushes the old state
//   onto a circular LIFO history. When the history is full, a push overwrites
//   the oldest entry. Undo pops the most recent entry back into the state.
//   Clear returns the state to RESET_STATE.
//
// Ports
//   clk, reset_n         : clock, asynchronous active-low reset
//   cmd, cmd_valid       : player command and its valid flag
//   cmd_ready            : command is accepted when high together with cmd_valid
//   undo, hold, clear    : restore previous state / freeze / return to RESET_STATE
//   rule_state, rule_cmd : current state and command, sent to the external rule
//   rule_next            : next state, returned combinationally by the rule
//   state                : registered current state
//   step_done, changed   : one-cycle pulses after a step / after a step that changed the state
//   step_count           : saturating count of accepted commands
//   hist_level           : number of valid history entries
//   hist_empty           : high when no history entry is valid
//   hist_full            : high when every history entry is valid
module state_step_engine #(
  parameter int                 STATE_W     = 10,
  parameter int                 CMD_W       = 3,
  parameter int                 DEPTH       = 4,
  parameter int                 CNT_W       = 8,
  parameter logic [STATE_W-1:0] RESET_STATE = STATE_W'('h110)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [CMD_W-1:0]           cmd,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       undo,
  input  logic                       hold,
  input  logic                       clear,
  output logic [STATE_W-1:0]         rule_state,
  output logic [CMD_W-1:0]           rule_cmd,
  input  logic [STATE_W-1:0]         rule_next,
  output logic [STATE_W-1:0]         state,
  output logic                       step_done,
  output logic                       changed,
  output logic [CNT_W-1:0]           step_count,
  output logic [$clog2(DEPTH):0]     hist_level,
  output logic                       hist_empty,
  output logic                       hist_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [STATE_W-1:0] hist_mem [DEPTH];
  logic [STATE_W-1:0] state_p1;
  logic [CNT_W-1:0]   cnt_p1;
  logic [LVL_W-1:0]   level_p1;
  logic [PTR_W-1:0]   ptr_p1;
  logic               vld_p1;
  logic               chg_p1;

  logic               accept_p0;
  logic               undo_p0;
  logic               step_p0;
  logic [STATE_W-1:0] top_p0;
  logic [STATE_W-1:0] next_p0;

  // The counter stops at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Pushing into a full history overwrites the oldest entry, so the level stays at DEPTH.
  function automatic logic [LVL_W-1:0] sat_level(input logic [LVL_W-1:0] v);
    return (v == LVL_W'(DEPTH)) ? v : v + LVL_W'(1);
  endfunction

  // Stage p0: decode the request and pick the next state
  assign cmd_ready  = ~hold & ~clear;
  assign accept_p0  = cmd_valid & cmd_ready;
  // cmd_ready already covers hold and clear, so an accepted command always wins over undo.
  assign undo_p0    = undo & ~hold & ~clear & ~hist_empty & ~accept_p0;
  assign step_p0    = clear | accept_p0 | undo_p0;
  // ptr_p1 addresses the next free slot, so the newest entry sits one slot below it.
  assign top_p0     = hist_mem[ptr_p1 - PTR_W'(1)];

  always_comb begin
    next_p0 = state_p1;
    if (clear)          next_p0 = RESET_STATE;
    else if (accept_p0) next_p0 = rule_next;
    else if (undo_p0)   next_p0 = top_p0;
  end

  // Stage p1: registered state, history bookkeeping and step pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_p1 <= RESET_STATE;
      cnt_p1   <= '0;
      level_p1 <= '0;
      ptr_p1   <= '0;
      vld_p1   <= 1'b0;
      chg_p1   <= 1'b0;
    end else begin
      state_p1 <= next_p0;
      vld_p1   <= step_p0;
      chg_p1   <= step_p0 & (next_p0 != state_p1);
      if (clear) begin
        cnt_p1   <= '0;
        level_p1 <= '0;
        ptr_p1   <= '0;
      end else if (accept_p0) begin
        cnt_p1   <= sat_inc(cnt_p1);
        level_p1 <= sat_level(level_p1);
        ptr_p1   <= ptr_p1 + PTR_W'(1);
      end else if (undo_p0) begin
        level_p1 <= level_p1 - LVL_W'(1);
        ptr_p1   <= ptr_p1 - PTR_W'(1);
      end
    end
  end

  // The history storage is not reset; hist_level decides which entries are valid.
  always_ff @(posedge clk) begin
    if (accept_p0) hist_mem[ptr_p1] <= state_p1;
  end

  assign rule_state = state_p1;
  assign rule_cmd   = cmd;
  assign state      = state_p1;
  assign step_done  = vld_p1;
  assign changed    = chg_p1;
  assign step_count = cnt_p1;
  assign hist_level = level_p1;
  assign hist_empty = (level_p1 == '0);
  assign hist_full  = (level_p1 == LVL_W'(DEPTH));

endmodule
